// File: rtl/plat_collision_scan.sv
`default_nettype none
// ============================================================================
// Module   : plat_collision_scan
// Purpose  : Scans the current block's packed platform tables, one platform
//            per cycle, for a falling crossing of a platform top by the
//            player's feet. The highest such platform is reported.
// Options  : PLAT_COLLISION_CEIL_EN - also flag a rising crossing of a
//            platform underside on the bump output.
// Revision : 1.0 - initial release
// ============================================================================
module plat_collision_scan #(
   parameter int PLATFORM_NUM_PER_BLOCK = 7,
   parameter int PHY_WIDTH              = 16,
   parameter int BLOCK_LEN_WIDTH        = 4,
   parameter int TILE_W                 = 16,
   parameter int PLAYER_W               = 16,
   parameter int PLAT_THICK             = 8
) (
   input  logic                                          sys_clk,
   input  logic                                          sys_rst_n,
   input  logic                                          start,
   input  logic                                          block_switch,
   input  logic [PHY_WIDTH-1:0]                          player_x,
   input  logic [PHY_WIDTH-1:0]                          prev_feet_y,
   input  logic [PHY_WIDTH-1:0]                          next_feet_y,
   input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_x,
   input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_y,
   input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          land,
   output logic [PHY_WIDTH-1:0]                          land_y,
   output logic [2:0]                                    land_idx,
   output logic                                          bump
);

   localparam int N = PLATFORM_NUM_PER_BLOCK;
   localparam logic [2:0]         LAST_IDX   = 3'(N - 1);
   localparam logic [PHY_WIDTH:0] TILE_W_X   = (PHY_WIDTH + 1)'(TILE_W);
   localparam logic [PHY_WIDTH:0] PLAYER_W_X = (PHY_WIDTH + 1)'(PLAYER_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q,      state_d;
   logic [2:0]             idx_q,        idx_d;
   logic [PHY_WIDTH-1:0]   px_q,         px_d;
   logic [PHY_WIDTH-1:0]   prev_q,       prev_d;
   logic [PHY_WIDTH-1:0]   next_q,       next_d;
   logic                   best_vld_q,   best_vld_d;
   logic [PHY_WIDTH-1:0]   best_y_q,     best_y_d;
   logic [2:0]             best_idx_q,   best_idx_d;
   logic                   bump_acc_q,   bump_acc_d;
   logic                   land_q,       land_d;
   logic [PHY_WIDTH-1:0]   land_y_q,     land_y_d;
   logic [2:0]             land_idx_q,   land_idx_d;
   logic                   bump_q,       bump_d;

   logic [PHY_WIDTH-1:0]       cur_x;
   logic [PHY_WIDTH-1:0]       cur_y;
   logic [BLOCK_LEN_WIDTH-1:0] cur_len;
   logic [PHY_WIDTH:0]         player_left;
   logic [PHY_WIDTH:0]         player_right;
   logic [PHY_WIDTH:0]         plat_left;
   logic [PHY_WIDTH:0]         plat_right;
   logic                       overlap;
   logic                       fall_cross;
   logic                       hit;
   logic                       bump_hit;
   logic                       take_hit;
   logic                       scan_vld;
   logic [PHY_WIDTH-1:0]       scan_y;
   logic [2:0]                 scan_idx;
   logic                       scan_bump;

   // Select the live table entry addressed by the scan index.
   always_comb begin
      cur_x   = '0;
      cur_y   = '0;
      cur_len = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == 3'(i)) begin
            cur_x   = plat_relative_x[i*PHY_WIDTH +: PHY_WIDTH];
            cur_y   = plat_relative_y[i*PHY_WIDTH +: PHY_WIDTH];
            cur_len = plat_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
         end
      end
   end

   // Hit test for the current platform; sums carry one extra bit so they never wrap.
   always_comb begin
      player_left  = {1'b0, px_q};
      player_right = player_left + PLAYER_W_X;
      plat_left    = {1'b0, cur_x};
      plat_right   = plat_left + ((PHY_WIDTH + 1)'(cur_len) * TILE_W_X);
      overlap      = (cur_len != '0) && (player_right > plat_left) && (player_left < plat_right);
      fall_cross   = (prev_q >= cur_y) && (next_q <= cur_y);
      hit          = overlap && fall_cross;
   end

`ifdef PLAT_COLLISION_CEIL_EN
   localparam logic [PHY_WIDTH:0] THICK_X = (PHY_WIDTH + 1)'(PLAT_THICK);

   logic signed [PHY_WIDTH:0] underside;

   // Rising crossing of the platform underside; platforms too low to have a
   // non-negative underside are excluded.
   always_comb begin
      underside = $signed({1'b0, cur_y}) - $signed(THICK_X);
      bump_hit  = overlap
                  && ({1'b0, cur_y} >= THICK_X)
                  && ($signed({1'b0, prev_q}) <  underside)
                  && ($signed({1'b0, next_q}) >= underside);
   end
`else
   // Without the ceiling option nothing ever bumps, so the bump path folds to 0.
   always_comb begin
      bump_hit = 1'b0;
   end
`endif

   // Best-hit tracking including the platform under test this cycle; strict
   // compare keeps the lower index on equal heights since indices ascend.
   always_comb begin
      take_hit  = hit && (!best_vld_q || (cur_y > best_y_q));
      scan_vld  = best_vld_q || hit;
      scan_y    = take_hit ? cur_y : best_y_q;
      scan_idx  = take_hit ? idx_q : best_idx_q;
      scan_bump = bump_acc_q || bump_hit;
   end

   // Next-state and datapath updates for the scan controller.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      px_d       = px_q;
      prev_d     = prev_q;
      next_d     = next_q;
      best_vld_d = best_vld_q;
      best_y_d   = best_y_q;
      best_idx_d = best_idx_q;
      bump_acc_d = bump_acc_q;
      land_d     = land_q;
      land_y_d   = land_y_q;
      land_idx_d = land_idx_q;
      bump_d     = bump_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SCAN;
               idx_d      = '0;
               px_d       = player_x;
               prev_d     = prev_feet_y;
               next_d     = next_feet_y;
               best_vld_d = 1'b0;
               best_y_d   = '0;
               best_idx_d = '0;
               bump_acc_d = 1'b0;
            end
         end
         ST_SCAN: begin
            if (block_switch) begin
               // Tables are being replaced: discard everything seen so far.
               idx_d      = '0;
               best_vld_d = 1'b0;
               best_y_d   = '0;
               best_idx_d = '0;
               bump_acc_d = 1'b0;
            end else begin
               best_vld_d = scan_vld;
               best_y_d   = scan_y;
               best_idx_d = scan_idx;
               bump_acc_d = scan_bump;
               if (idx_q == LAST_IDX) begin
                  // Publish results so they are valid alongside done.
                  state_d = ST_DONE;
                  land_d  = scan_vld;
                  bump_d  = scan_bump;
                  if (scan_vld) begin
                     land_y_d   = scan_y;
                     land_idx_d = scan_idx;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         px_q       <= '0;
         prev_q     <= '0;
         next_q     <= '0;
         best_vld_q <= 1'b0;
         best_y_q   <= '0;
         best_idx_q <= '0;
         bump_acc_q <= 1'b0;
         land_q     <= 1'b0;
         land_y_q   <= '0;
         land_idx_q <= '0;
         bump_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         px_q       <= px_d;
         prev_q     <= prev_d;
         next_q     <= next_d;
         best_vld_q <= best_vld_d;
         best_y_q   <= best_y_d;
         best_idx_q <= best_idx_d;
         bump_acc_q <= bump_acc_d;
         land_q     <= land_d;
         land_y_q   <= land_y_d;
         land_idx_q <= land_idx_d;
         bump_q     <= bump_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign land     = land_q;
   assign land_y   = land_y_q;
   assign land_idx = land_idx_q;
   assign bump     = bump_q;

endmodule
`default_nettype wire
